// File: rtl/mcycle_unit.sv
// Iterative multiply/divide unit for the execute stage: one bit per cycle,
// Start/Busy/Done handshake, fixed WIDTH+2 cycle latency.
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic             Signed,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, SIGN, DONE} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               div_q, div_d;
  logic               neg_res_q, neg_res_d;   // product / quotient negated
  logic               neg_rem_q, neg_rem_d;   // remainder follows dividend sign
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;       // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   dvd_q, dvd_d;           // raw dividend, returned on divide by zero
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   res1_q, res1_d, res2_q, res2_d;
  logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

  logic [WIDTH-1:0]   mag1, mag2, hi, lo, rem_sub, rem_new;
  logic [WIDTH:0]     add_sum, rem_sh;
  logic               fits;

  assign mag1 = (Signed && Operand1[WIDTH-1]) ? -Operand1 : Operand1;
  assign mag2 = (Signed && Operand2[WIDTH-1]) ? -Operand2 : Operand2;

  assign hi      = acc_q[2*WIDTH-1:WIDTH];
  assign lo      = acc_q[WIDTH-1:0];
  assign add_sum = {1'b0, hi} + {1'b0, mcand_q};
  // Restoring step: partial remainder shifted left with the next dividend bit.
  assign rem_sh  = {hi, lo[WIDTH-1]};
  assign fits    = rem_sh >= {1'b0, mcand_q};
  assign rem_sub = rem_sh[WIDTH-1:0] - mcand_q;
  assign rem_new = fits ? rem_sub : rem_sh[WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    zero_d    = zero_q;
    mcand_d   = mcand_q;
    dvd_d     = dvd_q;
    acc_d     = acc_q;
    res1_d    = res1_q;
    res2_d    = res2_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        busy_d = 1'b0;
        if (Start) begin
          div_d     = MCycleOp;
          neg_res_d = Signed & (Operand1[WIDTH-1] ^ Operand2[WIDTH-1]);
          neg_rem_d = Signed & Operand1[WIDTH-1];
          zero_d    = (Operand2 == '0);
          dvd_d     = Operand1;
          mcand_d   = MCycleOp ? mag2 : mag1;
          acc_d     = {{WIDTH{1'b0}}, (MCycleOp ? mag1 : mag2)};
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (div_q) acc_d = {rem_new, lo[WIDTH-2:0], fits};
        else       acc_d = {(lo[0] ? add_sum : {1'b0, hi}), lo[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = SIGN;
      end
      SIGN: begin
        if (!div_q) begin
          {res2_d, res1_d} = neg_res_q ? -acc_q : acc_q;
        end else if (zero_q) begin
          res1_d = '1;
          res2_d = dvd_q;
        end else begin
          res1_d = neg_res_q ? -lo : lo;
          res2_d = neg_rem_q ? -hi : hi;
        end
        dbz_d   = div_q & zero_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      mcand_q   <= '0;
      dvd_q     <= '0;
      acc_q     <= '0;
      res1_q    <= '0;
      res2_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      zero_q    <= zero_d;
      mcand_q   <= mcand_d;
      dvd_q     <= dvd_d;
      acc_q     <= acc_d;
      res1_q    <= res1_d;
      res2_q    <= res2_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign Result1   = res1_q;
  assign Result2   = res2_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_mcycle_unit.sv
// Bench for mcycle_unit: a 32-bit and an 8-bit instance checked against an
// arithmetic reference model (longint multiply/divide).
module tb_mcycle_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        st32, op32, sg32, bz32, dn32, dz32;
  logic [31:0] a32, b32, r1_32, r2_32;
  logic        st8, op8, sg8, bz8, dn8, dz8;
  logic [7:0]  a8, b8, r1_8, r2_8;

  int checks = 0;
  int failures = 0;

  mcycle_unit #(.WIDTH(32)) u32 (
    .CLK(clk), .RESET(rst), .Start(st32), .MCycleOp(op32), .Signed(sg32),
    .Operand1(a32), .Operand2(b32), .Result1(r1_32), .Result2(r2_32),
    .Busy(bz32), .Done(dn32), .DivByZero(dz32));

  mcycle_unit #(.WIDTH(8)) u8 (
    .CLK(clk), .RESET(rst), .Start(st8), .MCycleOp(op8), .Signed(sg8),
    .Operand1(a8), .Operand2(b8), .Result1(r1_8), .Result2(r2_8),
    .Busy(bz8), .Done(dn8), .DivByZero(dz8));

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void ref_model(input int w, input bit div, input bit sgn,
                                    input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r1, output logic [31:0] r2,
                                    output bit dz);
    longint sa, sb, p, mask;
    mask = (longint'(1) <<< w) - 1;
    sa = {32'd0, a} & mask;
    sb = {32'd0, b} & mask;
    dz = 1'b0;
    if (sgn && a[w-1]) sa = sa - (longint'(1) <<< w);
    if (sgn && b[w-1]) sb = sb - (longint'(1) <<< w);
    if (!div) begin
      p  = sa * sb;
      r1 = 32'(p & mask);
      r2 = 32'((p >>> w) & mask);
    end else if (sb == 0) begin
      dz = 1'b1;
      r1 = 32'(mask);
      r2 = a;
    end else begin
      r1 = 32'((sa / sb) & mask);
      r2 = 32'((sa % sb) & mask);
    end
  endfunction

  task automatic scramble();
    op32 = 1'($urandom); sg32 = 1'($urandom); a32 = $urandom; b32 = $urandom;
    op8  = 1'($urandom); sg8  = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  // Issue one op, scramble inputs once Start is sampled, wait for Done.
  // lat counts edges from the sampling edge to the Done edge; -1 on timeout.
  task automatic issue(input bit w8, input bit op, input bit sg,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r1, output logic [31:0] r2,
                       output bit dz, output int lat, output int bc);
    bit got;
    @(negedge clk);
    if (w8) begin st8 = 1'b1; op8 = op; sg8 = sg; a8 = a[7:0]; b8 = b[7:0]; end
    else    begin st32 = 1'b1; op32 = op; sg32 = sg; a32 = a; b32 = b; end
    lat = 0; bc = 0; got = 1'b0; r1 = '0; r2 = '0; dz = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (i == 0) begin st8 = 1'b0; st32 = 1'b0; scramble(); end
      if (w8 ? bz8 : bz32) bc++;
      if (w8 ? dn8 : dn32) begin
        got = 1'b1;
        r1 = w8 ? {24'd0, r1_8} : r1_32;
        r2 = w8 ? {24'd0, r2_8} : r2_32;
        dz = w8 ? dz8 : dz32;
      end
    end
    if (!got) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; st32 = 1'b0; st8 = 1'b0; scramble();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({r1_32, r2_32, bz32, dn32, dz32} !== 67'd0) begin
      failures++;
      $display("FAIL reset32 got r1=%h r2=%h busy=%b done=%b dbz=%b want all 0",
               r1_32, r2_32, bz32, dn32, dz32);
    end
    checks++;
    if ({r1_8, r2_8, bz8, dn8, dz8} !== 19'd0) begin
      failures++;
      $display("FAIL reset8 got r1=%h r2=%h busy=%b done=%b dbz=%b want all 0",
               r1_8, r2_8, bz8, dn8, dz8);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed32();
    logic [31:0] va[6] = '{32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'h80000000};
    logic [31:0] vb[6] = '{32'hFFFFFFFF, 32'd6, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF};
    bit          vo[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    bit          vs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] e1[6] = '{32'h00000001, 32'hFFFFFFD6, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] e2[6] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100, 32'd100, 32'd0};
    bit          ez[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] r1, r2;
    bit dz;
    int lat, bc;
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, vo[i], vs[i], va[i], vb[i], r1, r2, dz, lat, bc);
      checks++;
      if (lat !== 34) begin failures++; $display("FAIL dir32[%0d] latency got=%0d want=34", i, lat); end
      checks++;
      if (bc !== 33) begin failures++; $display("FAIL dir32[%0d] busy_cycles got=%0d want=33", i, bc); end
      checks++;
      if (r1 !== e1[i]) begin failures++; $display("FAIL dir32[%0d] result1 got=%h want=%h", i, r1, e1[i]); end
      checks++;
      if (r2 !== e2[i]) begin failures++; $display("FAIL dir32[%0d] result2 got=%h want=%h", i, r2, e2[i]); end
      checks++;
      if (dz !== ez[i]) begin failures++; $display("FAIL dir32[%0d] divbyzero got=%b want=%b", i, dz, ez[i]); end
    end
  endtask

  task automatic test_random32();
    logic [31:0] a, b, r1, r2, e1, e2;
    bit op, sg, dz, ez;
    int lat, bc;
    for (int i = 0; i < 12; i++) begin
      op = 1'(i); sg = 1'(i >> 1);
      a = $urandom; b = (i % 5 == 4) ? 32'd0 : $urandom >> $urandom_range(24);
      ref_model(32, op, sg, a, b, e1, e2, ez);
      issue(1'b0, op, sg, a, b, r1, r2, dz, lat, bc);
      checks++;
      if (r1 !== e1 || r2 !== e2 || dz !== ez || lat !== 34) begin
        failures++;
        $display("FAIL rand32 op=%b s=%b a=%h b=%h got r1=%h r2=%h dz=%b lat=%0d want r1=%h r2=%h dz=%b lat=34",
                 op, sg, a, b, r1, r2, dz, lat, e1, e2, ez);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] qa[4], qb[4], e1[4], e2[4];
    bit qo[4], qs[4], ez[4];
    int n = 0, last = -1;
    for (int i = 0; i < 4; i++) begin
      qo[i] = 1'(i); qs[i] = 1'($urandom); qa[i] = $urandom; qb[i] = $urandom >> 8;
      ref_model(32, qo[i], qs[i], qa[i], qb[i], e1[i], e2[i], ez[i]);
    end
    @(negedge clk);
    st32 = 1'b1; op32 = qo[0]; sg32 = qs[0]; a32 = qa[0]; b32 = qb[0];
    for (int cyc = 0; cyc < 400 && n < 4; cyc++) begin
      @(posedge clk); #1;
      if (dn32) begin
        checks++;
        if (r1_32 !== e1[n] || r2_32 !== e2[n] || dz32 !== ez[n]) begin
          failures++;
          $display("FAIL b2b[%0d] got r1=%h r2=%h dz=%b want r1=%h r2=%h dz=%b",
                   n, r1_32, r2_32, dz32, e1[n], e2[n], ez[n]);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last !== 34) begin
            failures++;
            $display("FAIL b2b_interval got=%0d want=34", cyc - last);
          end
        end
        last = cyc;
        n++;
        if (n < 4) begin op32 = qo[n]; sg32 = qs[n]; a32 = qa[n]; b32 = qb[n]; end
        else st32 = 1'b0;
      end else if (bz32) begin
        a32 = $urandom; b32 = $urandom; op32 = 1'($urandom); sg32 = 1'($urandom);
      end
    end
    st32 = 1'b0;
    checks++;
    if (n !== 4) begin failures++; $display("FAIL b2b_count got=%0d want=4", n); end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] r1, r2, e1, e2;
    bit dz, ez;
    int lat, bc;
    @(negedge clk);
    st32 = 1'b1; op32 = 1'b0; sg32 = 1'b0; a32 = 32'h12345678; b32 = 32'h9ABCDEF1;
    @(posedge clk); #1;
    st32 = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; st32 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({r1_32, r2_32, bz32, dn32, dz32} !== 67'd0) begin
      failures++;
      $display("FAIL reset_midrun got r1=%h r2=%h busy=%b done=%b dbz=%b want all 0",
               r1_32, r2_32, bz32, dn32, dz32);
    end
    @(negedge clk);
    rst = 1'b0; st32 = 1'b0;
    @(posedge clk);
    ref_model(32, 1'b1, 1'b1, 32'hFFFFF000, 32'd7, e1, e2, ez);
    issue(1'b0, 1'b1, 1'b1, 32'hFFFFF000, 32'd7, r1, r2, dz, lat, bc);
    checks++;
    if (r1 !== e1 || r2 !== e2 || dz !== ez || lat !== 34) begin
      failures++;
      $display("FAIL after_reset got r1=%h r2=%h dz=%b lat=%0d want r1=%h r2=%h dz=%b lat=34",
               r1, r2, dz, lat, e1, e2, ez);
    end
  endtask

  task automatic test_sweep8();
    logic [7:0]  edge_vals[6] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'hFE};
    logic [31:0] a, b, r1, r2, e1, e2;
    bit op, sg, dz, ez;
    int lat, bc;
    for (int i = 0; i < 300; i++) begin
      op = 1'(i); sg = 1'(i >> 1);
      a = {24'd0, ($urandom_range(3) == 0) ? edge_vals[$urandom_range(5)] : 8'($urandom)};
      b = {24'd0, ($urandom_range(3) == 0) ? edge_vals[$urandom_range(5)] : 8'($urandom)};
      ref_model(8, op, sg, a, b, e1, e2, ez);
      issue(1'b1, op, sg, a, b, r1, r2, dz, lat, bc);
      checks++;
      if (r1 !== e1 || r2 !== e2 || dz !== ez || lat !== 10 || bc !== 9) begin
        failures++;
        $display("FAIL sweep8 op=%b s=%b a=%h b=%h got r1=%h r2=%h dz=%b lat=%0d busy=%0d want r1=%h r2=%h dz=%b lat=10 busy=9",
                 op, sg, a[7:0], b[7:0], r1[7:0], r2[7:0], dz, lat, bc, e1[7:0], e2[7:0], ez);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed32();
    test_random32();
    test_back_to_back();
    test_reset_midrun();
    test_sweep8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
